fsk_tx_ctrl: RTL

FSK_TX_CTRL -- requirements
Module: fsk_tx_ctrl

---
 rtl/fsk_tx_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fsk_tx_ctrl.sv
// FSK transmit sequencer: frames symbols from a valid/ready source onto tone_sel at SYM_TICKS rate ticks each.
// Optional preamble of alternating 0/F symbols when FSK_PREAMBLE_EN is defined.
`timescale 1ns/1ps
module fsk_tx_ctrl #(
    parameter int unsigned TICK_DIV    = 20,
    parameter int unsigned SYM_TICKS   = 16,
    parameter int unsigned GUARD_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [3:0] sym_data,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic       div_en,
    output logic [3:0] tone_sel,
    output logic       tone_valid,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
`ifdef FSK_PREAMBLE_EN
    localparam logic [2:0] ST_PRE   = 3'd2;
`endif
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_GUARD = 3'd4;

    localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SMAX = (SYM_TICKS > GUARD_TICKS) ? SYM_TICKS : GUARD_TICKS;
    localparam int unsigned SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SYM_LAST   = SW'(SYM_TICKS - 1);
    localparam logic [SW-1:0] GUARD_LAST = SW'(GUARD_TICKS - 1);

    logic [2:0]    state, state_nxt;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] seg_cnt;
    logic [SW-1:0] seg_last;
    logic [7:0]    len_q;
    logic [7:0]    sym_left;
    logic [3:0]    buf_data;
    logic          buf_full;
    logic          running, tick, seg_end, hs;
`ifdef FSK_PREAMBLE_EN
    logic [2:0]    pre_cnt;
`endif

    always_comb begin
        running = (state == ST_DATA) || (state == ST_GUARD);
        tone_valid = (state == ST_DATA);
`ifdef FSK_PREAMBLE_EN
        running = running || (state == ST_PRE);
        tone_valid = tone_valid || (state == ST_PRE);
`endif
        // One counter serves both symbol and guard intervals; only its wrap point differs.
        seg_last   = (state == ST_GUARD) ? GUARD_LAST : SYM_LAST;
        tick       = running && (tick_cnt == TICK_LAST);
        seg_end    = tick && (seg_cnt == seg_last);
        busy       = (state != ST_IDLE);
        div_en     = running;
        sym_ready  = (state == ST_LOAD) ||
                     ((state == ST_DATA) && !buf_full && (sym_left != '0));
        hs         = sym_valid && sym_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start && (frame_len != '0)) state_nxt = ST_LOAD;
`ifdef FSK_PREAMBLE_EN
            ST_LOAD:  if (hs) state_nxt = ST_PRE;
            ST_PRE:   if (seg_end && (pre_cnt == 3'd7)) state_nxt = ST_DATA;
`else
            ST_LOAD:  if (hs) state_nxt = ST_DATA;
`endif
            ST_DATA:  if (seg_end && (sym_left == '0)) state_nxt = ST_GUARD;
            ST_GUARD: if (seg_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            seg_cnt    <= '0;
            len_q      <= '0;
            sym_left   <= '0;
            buf_data   <= '0;
            buf_full   <= 1'b0;
            tone_sel   <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
`ifdef FSK_PREAMBLE_EN
            pre_cnt    <= '0;
`endif
        end else begin
            state      <= state_nxt;
            frame_done <= (state == ST_GUARD) && seg_end;

            if ((state_nxt != state) || !running) begin
                tick_cnt <= '0;
                seg_cnt  <= '0;
            end else if (tick) begin
                tick_cnt <= '0;
                seg_cnt  <= seg_end ? '0 : seg_cnt + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start && (frame_len != '0)) begin
                        len_q    <= frame_len;
                        underrun <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        sym_left <= len_q - 1'b1;
`ifdef FSK_PREAMBLE_EN
                        buf_data <= sym_data;
                        buf_full <= 1'b1;
                        tone_sel <= 4'h0;
                        pre_cnt  <= '0;
`else
                        // Buffer capture and DATA-entry unload collapse into one edge.
                        tone_sel <= sym_data;
                        buf_full <= 1'b0;
`endif
                    end
                end
`ifdef FSK_PREAMBLE_EN
                ST_PRE: begin
                    if (seg_end) begin
                        if (pre_cnt == 3'd7) begin
                            tone_sel <= buf_data;
                            buf_full <= 1'b0;
                        end else begin
                            pre_cnt  <= pre_cnt + 1'b1;
                            tone_sel <= ~tone_sel;
                        end
                    end
                end
`endif
                ST_DATA: begin
                    if (seg_end) begin
                        if (sym_left == '0) begin
                            tone_sel <= '0;
                        end else if (buf_full) begin
                            tone_sel <= buf_data;
                            buf_full <= 1'b0;
                            sym_left <= sym_left - 1'b1;
                        end else if (hs) begin
                            tone_sel <= sym_data;
                            sym_left <= sym_left - 1'b1;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end else if (hs) begin
                        buf_data <= sym_data;
                        buf_full <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
